// File: rtl/uart_tx_if.sv
// Valid/ready handshake carrying one parallel word into the UART transmitter.
//   data_in : word to transmit, sampled by the slave on acceptance
//   valid   : master presents data_in
//   ready   : slave can accept a word
// master modport: the word source; slave modport: the transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 valid;
    logic                 ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, STOP_BITS stop bits. Bit period is derived from clk by an
// internal counter.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : word handshake (data_in, valid in; ready out)
//   txd  : serial line, registered, idle high
//   busy : frame in progress
//   done : one-cycle pulse in the last cycle of a frame
module uart_tx #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      txd,
    output logic      busy,
    output logic      done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_SLAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 acc;
    logic                 ready_q;
    logic                 bit_end;

    assign bus.ready = ready_q;
    assign bit_end   = (state != S_IDLE) && (cnt == CNT_LAST);

    // Frame sequencer; txd is always loaded one edge ahead so the line is a flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            acc     <= 1'b0;
            txd     <= 1'b1;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE) begin
                cnt <= bit_end ? '0 : cnt + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (bus.valid) begin
                        shreg   <= bus.data_in;
                        acc     <= 1'b0;
                        idx     <= '0;
                        cnt     <= '0;
                        txd     <= 1'b0;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        txd   <= shreg[0];
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        acc   <= acc ^ shreg[0];
                        shreg <= shreg >> 1;
                        if (idx == IDX_DLAST) begin
                            idx <= '0;
                            if (PARITY_EN != 0) begin
                                // Accumulator including the bit just finished.
                                txd   <= acc ^ shreg[0] ^ 1'(PARITY_ODD);
                                state <= S_PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                            txd <= shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Raised one cycle early so done lands on the final stop cycle.
                    if ((idx == IDX_SLAST) && (cnt == CNT_PRE)) begin
                        done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (idx == IDX_SLAST) begin
                            idx     <= '0;
                            ready_q <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Three instances, all CLKS_PER_BIT=4, 8 data bits:
//   sel 0: even parity, 1 stop; sel 1: odd parity, 1 stop; sel 2: no parity, 2 stops.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int NV  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();

    logic [7:0] data_v [3];
    logic [2:0] valid_v;
    logic [2:0] ready_w;
    logic [2:0] txd_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    assign if0.data_in = data_v[0];
    assign if1.data_in = data_v[1];
    assign if2.data_in = data_v[2];
    assign if0.valid   = valid_v[0];
    assign if1.valid   = valid_v[1];
    assign if2.valid   = valid_v[2];
    assign ready_w[0]  = if0.ready;
    assign ready_w[1]  = if1.ready;
    assign ready_w[2]  = if2.ready;

    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .txd(txd_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .txd(txd_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .bus(if2.slave), .txd(txd_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [15:0] exp;
    } vec_t;

    vec_t        vec [NV];
    logic [15:0] sb [$];
    int          n_chk = 0;
    int          n_err = 0;

    function automatic int par_en(input int sel);
        return (sel == 2) ? 0 : 1;
    endfunction

    function automatic int nbits(input int sel);
        return (sel == 2) ? 11 : 11;
    endfunction

    // Reference frame: bit i of the result is the i-th bit on the line.
    function automatic logic [15:0] model(input int sel, input logic [7:0] d);
        logic [15:0] f;
        int          p;
        f    = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        p = 9;
        if (par_en(sel) != 0) begin
            f[p] = (^d) ^ (sel == 1);
            p++;
        end
        while (p < nbits(sel)) begin
            f[p] = 1'b1;
            p++;
        end
        return f;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wait for ready, present the word, complete the handshake on the next edge.
    task automatic send(input int sel, input logic [7:0] d, input bit hold, input logic [15:0] exp);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready_w[sel] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", 16'(ready_w[sel]), 16'd1);
        data_v[sel]  = d;
        valid_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid_v[sel] = 1'b0;
        sb.push_back(exp);
    endtask

    // Called just after acceptance edge A; samples cycles A+1..A+F on the falling edge.
    task automatic check_frame(input int sel, input bit scramble, input string nm,
                               output logic [15:0] got);
        int          nc;
        bit          stable;
        bit          timing_ok;
        logic [15:0] exp;
        got       = '0;
        stable    = 1'b1;
        timing_ok = 1'b1;
        nc        = nbits(sel) * CPB;
        for (int k = 1; k <= nc; k++) begin
            int j;
            @(negedge clk);
            j = (k - 1) / CPB;
            if (((k - 1) % CPB) == 0) got[j] = txd_w[sel];
            else if (txd_w[sel] !== got[j]) stable = 1'b0;
            if (done_w[sel] !== 1'(k == nc)) timing_ok = 1'b0;
            if (ready_w[sel] !== 1'b0 || busy_w[sel] !== 1'b1) timing_ok = 1'b0;
            if (scramble) data_v[sel] = 8'($urandom);
        end
        if (sb.size() == 0) begin
            check({nm, "_sb_empty"}, 16'd0, 16'd1);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        check({nm, "_frame"}, got, exp);
        check({nm, "_bit_hold"}, 16'(stable), 16'd1);
        check({nm, "_done_timing"}, 16'(timing_ok), 16'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] got;
        for (int s = 0; s < 3; s++) data_v[s] = 8'h00;
        valid_v = 3'b000;

        vec[0] = '{0, 8'h55, 16'h04AA};
        vec[1] = '{1, 8'h07, 16'h040E};
        vec[2] = '{0, 8'h07, 16'h060E};
        vec[3] = '{2, 8'hA3, 16'h0746};
        for (int i = 4; i < NV; i++) begin
            vec[i].sel  = int'($urandom_range(0, 2));
            vec[i].data = 8'($urandom);
            vec[i].exp  = model(vec[i].sel, vec[i].data);
        end

        // Reset state
        #12;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_txd%0d", s),   16'(txd_w[s]),   16'd1);
            check($sformatf("rst_ready%0d", s), 16'(ready_w[s]), 16'd1);
            check($sformatf("rst_busy%0d", s),  16'(busy_w[s]),  16'd0);
            check($sformatf("rst_done%0d", s),  16'(done_w[s]),  16'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table-driven frames
        for (int i = 0; i < NV; i++) begin
            send(vec[i].sel, vec[i].data, 1'b0, vec[i].exp);
            check_frame(vec[i].sel, 1'b0, $sformatf("vec%0d", i), got);
            if (vec[i].sel != 2) begin
                // Receive-side parity check: XOR of data and parity equals the odd flag.
                check($sformatf("vec%0d_loopback_parity", i),
                      16'((^got[8:1]) ^ got[9]), 16'(vec[i].sel == 1));
            end
            @(negedge clk);
            check($sformatf("vec%0d_ready_back", i), 16'(ready_w[vec[i].sel]), 16'd1);
        end

        // Back-to-back with valid held high
        send(0, 8'h00, 1'b1, model(0, 8'h00));
        data_v[0] = 8'hFF;
        check_frame(0, 1'b0, "b2b_first", got);
        @(negedge clk);
        check("b2b_idle_gap_txd", 16'(txd_w[0]), 16'd1);
        check("b2b_idle_gap_ready", 16'(ready_w[0]), 16'd1);
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        sb.push_back(model(0, 8'hFF));
        check_frame(0, 1'b0, "b2b_second", got);

        // Data hold: data_in scrambled every cycle after acceptance
        send(1, 8'h96, 1'b0, model(1, 8'h96));
        check_frame(1, 1'b1, "data_hold", got);

        // Reset during data bit 3 (cycles A+17..A+20)
        send(0, 8'h3C, 1'b0, model(0, 8'h3C));
        for (int k = 1; k <= 18; k++) @(negedge clk);
        check("pre_rst_ready", 16'(ready_w[0]), 16'd0);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_txd",   16'(txd_w[0]),   16'd1);
        check("mid_rst_ready", 16'(ready_w[0]), 16'd1);
        check("mid_rst_busy",  16'(busy_w[0]),  16'd0);
        check("mid_rst_done",  16'(done_w[0]),  16'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", k), 16'({txd_w[0], ready_w[0]}), 16'd3);
        end
        send(0, 8'h3C, 1'b0, model(0, 8'h3C));
        check_frame(0, 1'b0, "post_rst_3c", got);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit half of the UART: accepts a parallel data word over a valid/ready handshake and shifts it out on a single line as start bit, data bits LSB first, an optional parity bit and stop bit(s). The block sits beside the receive path. Its parity bit is produced with the same running-XOR rule the receive-side parity checker evaluates, so a looped-back frame checks clean. A single counter divides the system clock to the bit period; no external baud tick is required.

## Interface

Parameters:
- `DATA_BITS`, default 8: data bits per frame, 5..9.
- `CLKS_PER_BIT`, default 16: clk cycles per bit period, ≥2.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `data_in`, input, DATA_BITS: word to transmit; sampled only on acceptance.
- `valid`, input, 1: `data_in` is presented.
- `ready`, output, 1: block can accept a word.
- `txd`, output, 1: serial line, registered, idle high.
- `busy`, output, 1: frame in progress.
- `done`, output, 1: one-cycle pulse when a frame ends.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `ready`=1, `busy`=0, `txd`=1.
  - `valid`=1 accepts the word (handshake). The block latches `data_in` into the shift register, clears the parity accumulator and moves to START.
- START: `txd`=0 for one bit period.
- DATA:
  - `txd` = shift register bit 0 for one bit period per bit.
  - At each bit boundary the accumulator XORs in the outgoing bit, then the register shifts right.
  - After bit DATA_BITS-1 the state moves to PARITY when `PARITY_EN`=1, otherwise to STOP.
- PARITY: `txd` = accumulator XOR `PARITY_ODD` for one bit period.
  - Even parity: the total count of ones over data plus parity is even.
  - Odd parity: that total is odd.
- STOP: `txd`=1 for STOP_BITS bit periods. On the last cycle of the final stop bit, `done`=1 and the state moves to IDLE.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps to 0. The bit boundary is count = CLKS_PER_BIT-1. Width is ceil(log2(CLKS_PER_BIT)).
- Data index counter: width ceil(log2(DATA_BITS+1)). It also counts stop bits in STOP.
- `ready` = (state == IDLE); `busy` = !ready.
- `valid` while `ready`=0 is ignored. Changes to `data_in` after acceptance have no effect on the frame.
- Reset:
  - `rst` asserted at any time, including mid-frame, forces immediately: state IDLE, `txd`=1, `ready`=1, `busy`=0, `done`=0, counters 0, accumulator 0.
  - A partial frame is abandoned, never resumed.
- Reset values: `txd`=1, `ready`=1, `busy`=0, `done`=0.

## Timing

- Handshake completes on the rising edge where `valid`=1 and `ready`=1 (cycle A).
- `txd` falls on edge A (visible from cycle A+1). `ready` drops on the same edge.
- Each bit holds exactly CLKS_PER_BIT cycles on `txd`.
- Frame length: F = (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, from A+1 to A+F inclusive.
- `done` is high during cycle A+F only. `ready` returns high at A+F+1.
- Back-to-back: if `valid` is held high, the next acceptance edge is A+F+1. The next start bit begins at A+F+2, so exactly one idle-high cycle separates consecutive frames.
- No combinational path exists from any input to `txd`. `ready` depends only on state.

## Test plan

- **Even parity frame.** CLKS_PER_BIT=4, even parity, 1 stop bit, send 0x55.
  - `txd` bit sequence: 0,1,0,1,0,1,0,1,0,0,1, each bit 4 cycles.
  - `done` pulses at cycle A+44. `ready` is high at A+45.
- **Odd parity frame.** PARITY_ODD=1, send 0x07. Parity bit = 0 (the even-parity setting gives 1).
  - Run the same frame in even mode; its parity bit must be 1.
  - Loopback into the receive-side parity checker reports no error in both modes.
- **No parity, 2 stop bits.** PARITY_EN=0, STOP_BITS=2, send 0xA3.
  - Sequence: 0,1,1,0,0,0,1,0,1,1,1.
  - Frame length 44 cycles; no parity slot.
- **Back-to-back frames.** Hold `valid`=1 with 0x00 then 0xFF.
  - Exactly one idle-high cycle between the first stop bit and the second start bit.
  - `valid` during `busy` never changes the frame in flight.
- **Reset mid-frame.** Assert `rst` during data bit 3.
  - `txd`=1, `ready`=1, `done`=0 are asserted without waiting for a clock edge.
  - After release, a fresh 0x3C transmits correctly from its start bit.
- **Data hold.** Change `data_in` every cycle after acceptance. The transmitted bits match the word latched at cycle A.
